// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: round sequencer for an iterative AES encryption core.
// The round datapath and the key schedule live outside this block. Each
// cycle the controller presents the state register, a round-key index and a
// datapath mode, then captures the combinational result. The initial
// AddRoundKey is followed by NR-1 full rounds and one final round, so
// ciphertext appears NR+1 edges after a block is accepted.
// Optional build macro AES_ROUND_CTRL_ABORT_EN adds an 'abort' input that
// drops the block in flight and returns the controller to IDLE.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 only in IDLE. out_valid is 1 only in DONE, and
// data_out holds there until out_ready is seen. Neither side may make its
// valid depend on the other side's ready.
module aes_round_ctrl #(
    parameter int NR = 10
) (
    input  logic         CLK,
    input  logic         RST,
`ifdef AES_ROUND_CTRL_ABORT_EN
    input  logic         abort,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic [3:0]   key_idx,
    input  logic [127:0] Key_exp,
    output logic [1:0]   dp_mode,
    output logic [127:0] dp_state,
    input  logic [127:0] dp_result,
    output logic         busy,
    output logic [2:0]   dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } fsm_e;

    localparam logic [3:0] LAST_FULL = 4'(NR - 1);
    localparam logic [3:0] KEY_LAST  = 4'(NR);

    localparam logic [1:0] MODE_ARK   = 2'd0;
    localparam logic [1:0] MODE_FULL  = 2'd1;
    localparam logic [1:0] MODE_FINAL = 2'd2;

    fsm_e         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         abort_req;

    // The round key goes straight from the key schedule into the datapath;
    // the controller only chooses which key is selected.
    logic         unused_key;
    assign unused_key = ^Key_exp;

`ifdef AES_ROUND_CTRL_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // State register: FSM, cipher state and round counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fsm_q   <= S_IDLE;
            state_q <= '0;
            cnt_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: load, sequence the rounds, wait for the consumer.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (fsm_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = data_in;
                    cnt_d   = '0;
                    fsm_d   = S_INIT;
                end
            end
            S_INIT: begin
                state_d = dp_result;
                cnt_d   = 4'd1;
                fsm_d   = S_ROUND;
            end
            S_ROUND: begin
                state_d = dp_result;
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == LAST_FULL) begin
                    fsm_d = S_FINAL;
                end
            end
            S_FINAL: begin
                state_d = dp_result;
                fsm_d   = S_DONE;
            end
            S_DONE: begin
                // Going straight back to IDLE guarantees one idle cycle
                // between blocks.
                if (out_ready) begin
                    fsm_d = S_IDLE;
                end
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
        // Abort wins over everything, including a pending out_ready.
        if (abort_req && (fsm_q != S_IDLE)) begin
            fsm_d = S_IDLE;
            cnt_d = '0;
        end
    end

    // Output decode: handshake flags and datapath control per state.
    always_comb begin
        in_ready    = (fsm_q == S_IDLE);
        busy        = (fsm_q != S_IDLE);
        out_valid   = (fsm_q == S_DONE);
        data_out    = state_q;
        dp_state    = state_q;
        dbg_state_o = fsm_q;
        key_idx     = 4'd0;
        dp_mode     = MODE_ARK;
        unique case (fsm_q)
            S_ROUND: begin
                key_idx = cnt_q;
                dp_mode = MODE_FULL;
            end
            S_FINAL: begin
                key_idx = KEY_LAST;
                dp_mode = MODE_FINAL;
            end
            default: begin
                key_idx = 4'd0;
                dp_mode = MODE_ARK;
            end
        endcase
    end

endmodule
